// File: rtl/ahim_tx_sequencer.sv
// Shares one PIO transmit unit between two ping-pong result banks.
// Grants banks round-robin, sequences TX clear/enable and releases each bank when it is done.
module ahim_tx_sequencer #(
  parameter int unsigned PIO_DATA_WIDTH = 32,
  parameter int unsigned UINT8_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      sys_enable,
  input  logic                      abort,
  input  logic                      err_clr,
  input  logic [1:0]                bank_ready,
  input  logic [UINT8_WIDTH-1:0]    bank_headcount0,
  input  logic [UINT8_WIDTH-1:0]    bank_headcount1,
  input  logic [PIO_DATA_WIDTH-1:0] bank_q0,
  input  logic [PIO_DATA_WIDTH-1:0] bank_q1,
  output logic [1:0]                bank_pop,
  output logic [1:0]                bank_release,
  input  logic                      tx_pop,
  input  logic                      tx_done,
  input  logic                      tx_wd_trigger,
  output logic                      tx_en,
  output logic                      tx_clear,
  output logic [UINT8_WIDTH-1:0]    tx_headcount,
  output logic [PIO_DATA_WIDTH-1:0] tx_q,
  output logic                      busy,
  output logic                      active_bank,
  output logic                      err_wd,
  output logic [7:0]                wd_err_count,
  output logic [CNT_WIDTH-1:0]      sent_count
);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StArm,
    StRun,
    StError,
    StRelease
  } state_e;

  state_e                 state_q, state_d;
  logic                   active_bank_q, active_bank_d;
  logic                   last_served_q, last_served_d;
  logic [UINT8_WIDTH-1:0] hc_q, hc_d;
  logic                   err_wd_q, err_wd_d;
  logic [7:0]             wd_cnt_q, wd_cnt_d;
  logic [CNT_WIDTH-1:0]   sent_q, sent_d;

  logic                   sel_bank;
  logic [UINT8_WIDTH-1:0] sel_hc;
  logic                   err_set;

  // On a tie the bank that was not served last wins.
  assign sel_bank = (bank_ready == 2'b11) ? ~last_served_q : bank_ready[1];
  assign sel_hc   = active_bank_q ? bank_headcount1 : bank_headcount0;

  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    last_served_d = last_served_q;
    hc_d          = hc_q;
    wd_cnt_d      = wd_cnt_q;
    sent_d        = sent_q;
    err_set       = 1'b0;
    tx_en         = 1'b0;
    tx_clear      = 1'b0;
    bank_pop      = 2'b00;
    bank_release  = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (sys_enable && !abort && (|bank_ready)) begin
          state_d       = StGrant;
          active_bank_d = sel_bank;
          last_served_d = sel_bank;
        end
      end
      StGrant: begin
        hc_d = sel_hc;
        // An empty frame skips the TX unit entirely.
        if (sel_hc == '0) begin
          state_d = StRelease;
        end else begin
          tx_clear = 1'b1;
          state_d  = StArm;
        end
      end
      StArm: begin
        tx_en   = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        tx_en                   = 1'b1;
        bank_pop[active_bank_q] = tx_pop;
        if (tx_done) begin
          sent_d  = sent_q + CNT_WIDTH'(1);
          state_d = StRelease;
        end else if (tx_wd_trigger) begin
          err_set = 1'b1;
          if (wd_cnt_q != 8'hff) begin
            wd_cnt_d = wd_cnt_q + 8'd1;
          end
          state_d = StError;
        end else if (abort) begin
          state_d = StError;
        end
      end
      StError: begin
        tx_clear = 1'b1;
        state_d  = StRelease;
      end
      StRelease: begin
        bank_release[active_bank_q] = 1'b1;
        state_d                     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A new watchdog event takes priority over a concurrent clear.
    if (err_set) begin
      err_wd_d = 1'b1;
    end else if (err_clr) begin
      err_wd_d = 1'b0;
    end else begin
      err_wd_d = err_wd_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      active_bank_q <= 1'b0;
      last_served_q <= 1'b1;
      hc_q          <= '0;
      err_wd_q      <= 1'b0;
      wd_cnt_q      <= 8'd0;
      sent_q        <= '0;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      last_served_q <= last_served_d;
      hc_q          <= hc_d;
      err_wd_q      <= err_wd_d;
      wd_cnt_q      <= wd_cnt_d;
      sent_q        <= sent_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign active_bank  = active_bank_q;
  assign tx_headcount = hc_q;
  assign tx_q         = active_bank_q ? bank_q1 : bank_q0;
  assign err_wd       = err_wd_q;
  assign wd_err_count = wd_cnt_q;
  assign sent_count   = sent_q;

endmodule

// File: tb/tb_ahim_tx_sequencer.sv
// Randomized frame-level bench: stimulus pushes expected per-frame results, a monitor checks
// them whenever the sequencer releases a bank.
module tb_ahim_tx_sequencer;
  localparam int DW = 32;
  localparam int HW = 8;
  localparam int CW = 16;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          sys_enable = 1'b0, abort = 1'b0, err_clr = 1'b0;
  logic [1:0]    bank_ready = 2'b00;
  logic [HW-1:0] bank_headcount0 = '0, bank_headcount1 = '0;
  logic [DW-1:0] bank_q0 = '0, bank_q1 = '0;
  logic          tx_pop = 1'b0, tx_done = 1'b0, tx_wd_trigger = 1'b0;
  logic [1:0]    bank_pop, bank_release;
  logic          tx_en, tx_clear, busy, active_bank, err_wd;
  logic [HW-1:0] tx_headcount;
  logic [DW-1:0] tx_q;
  logic [7:0]    wd_err_count;
  logic [CW-1:0] sent_count;

  ahim_tx_sequencer #(
    .PIO_DATA_WIDTH(DW),
    .UINT8_WIDTH   (HW),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .sys_enable     (sys_enable),
    .abort          (abort),
    .err_clr        (err_clr),
    .bank_ready     (bank_ready),
    .bank_headcount0(bank_headcount0),
    .bank_headcount1(bank_headcount1),
    .bank_q0        (bank_q0),
    .bank_q1        (bank_q1),
    .bank_pop       (bank_pop),
    .bank_release   (bank_release),
    .tx_pop         (tx_pop),
    .tx_done        (tx_done),
    .tx_wd_trigger  (tx_wd_trigger),
    .tx_en          (tx_en),
    .tx_clear       (tx_clear),
    .tx_headcount   (tx_headcount),
    .tx_q           (tx_q),
    .busy           (busy),
    .active_bank    (active_bank),
    .err_wd         (err_wd),
    .wd_err_count   (wd_err_count),
    .sent_count     (sent_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          bank;
    int          pops0;
    int          pops1;
    int          clears;
    int          en_cycles;
    int          sent;
    int          wdcnt;
    int          errwd;
    int          hc;
    logic [31:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: what software would observe from the frame history.
  int m_last = 1, m_sent = 0, m_wd = 0, m_errwd = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Monitor: accumulate per-frame activity, compare on every bank release.
  int   acc_p0 = 0, acc_p1 = 0, acc_clr = 0, acc_en = 0;
  exp_t mon_e;
  always @(negedge clk_in) begin
    if (!rst_n) begin
      acc_p0 = 0; acc_p1 = 0; acc_clr = 0; acc_en = 0;
    end else begin
      acc_p0  += int'(bank_pop[0]);
      acc_p1  += int'(bank_pop[1]);
      acc_clr += int'(tx_clear);
      acc_en  += int'(tx_en);
      if (bank_release != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_release", bank_release, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("release_bank", bank_release, (mon_e.bank == 1) ? 2 : 1);
          check("active_bank", active_bank, mon_e.bank);
          check("tx_headcount", tx_headcount, mon_e.hc);
          check("tx_q", tx_q, mon_e.q);
          check("pops_bank0", acc_p0, mon_e.pops0);
          check("pops_bank1", acc_p1, mon_e.pops1);
          check("tx_clear_pulses", acc_clr, mon_e.clears);
          check("tx_en_cycles", acc_en, mon_e.en_cycles);
          check("sent_count", sent_count, mon_e.sent);
          check("wd_err_count", wd_err_count, mon_e.wdcnt);
          check("err_wd", err_wd, mon_e.errwd);
        end
        acc_p0 = 0; acc_p1 = 0; acc_clr = 0; acc_en = 0;
      end
    end
  end

  // act: 0 done, 1 watchdog, 2 done+watchdog, 3 abort in RUN, 4 abort raised in ARM.
  task automatic run_frame(input logic [1:0] pat, input int act, input int hc0, input int hc1);
    exp_t e;
    int   bank, hc, k;
    bit   ok, clr_with_wd;
    bank = (pat == 2'b11) ? (1 - m_last) : ((pat == 2'b01) ? 0 : 1);
    m_last = bank;
    hc = bank ? hc1 : hc0;
    k = (act == 0 || act == 2) ? hc : ((act == 4) ? 0 : int'($urandom_range(hc, 0)));
    clr_with_wd = 1'($urandom_range(1, 0));

    bank_headcount0 = HW'(hc0);
    bank_headcount1 = HW'(hc1);
    bank_q0 = $urandom;
    bank_q1 = $urandom;

    e.bank = bank;
    e.hc   = hc;
    e.q    = bank ? bank_q1 : bank_q0;
    if (hc == 0) begin
      e.clears = 0; e.en_cycles = 0; k = 0;
    end else begin
      e.en_cycles = k + 2;
      if (act == 0 || act == 2) begin
        e.clears = 1;
        m_sent = (m_sent + 1) % 65536;
      end else begin
        e.clears = 2;
        if (act == 1) begin
          m_errwd = 1;
          if (m_wd < 255) m_wd++;
        end
      end
    end
    e.pops0 = (bank == 0) ? k : 0;
    e.pops1 = (bank == 1) ? k : 0;
    e.sent  = m_sent;
    e.wdcnt = m_wd;
    e.errwd = m_errwd;
    exp_q.push_back(e);

    bank_ready = pat;
    sys_enable = 1'b1;
    if (hc != 0) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (tx_en) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        check("tx_en_timeout", 0, 1);
      end else begin
        // ARM cycle: mid-transfer sys_enable drop must not matter; a pop here must be ignored.
        sys_enable = 1'($urandom_range(1, 0));
        if (act == 4) abort = 1'b1;
        else tx_pop = 1'($urandom_range(1, 0));
        step();
        tx_pop = 1'b0;
        for (int i = 0; i < k; i++) begin
          tx_pop = 1'b1;
          step();
        end
        tx_pop = 1'b0;
        case (act)
          0: tx_done = 1'b1;
          1: begin tx_wd_trigger = 1'b1; err_clr = clr_with_wd; end
          2: begin tx_done = 1'b1; tx_wd_trigger = 1'b1; end
          default: abort = 1'b1;
        endcase
        step();
        tx_done = 1'b0; tx_wd_trigger = 1'b0; abort = 1'b0; err_clr = 1'b0;
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bank_release != 2'b00) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("release_timeout", 0, 1);
    bank_ready = 2'b00;
    sys_enable = 1'b1;
    step();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_errwd = 0;
    check("err_clr_drops_err_wd", err_wd, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int act, hc0, hc1;
    logic [1:0] pat;
    #2;
    check("rst_tx_en", tx_en, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    check("reset_tx_clear", tx_clear, 0);
    check("reset_bank_pop", bank_pop, 0);
    check("reset_bank_release", bank_release, 0);
    check("reset_active_bank", active_bank, 0);
    check("reset_err_wd", err_wd, 0);
    check("reset_wd_err_count", wd_err_count, 0);
    check("reset_sent_count", sent_count, 0);
    check("reset_tx_headcount", tx_headcount, 0);
    step();

    run_frame(2'b01, 0, 5, 3);
    for (int i = 0; i < 4; i++) run_frame(2'b11, 0, 2 + i, 3);
    run_frame(2'b10, 0, 4, 0);
    run_frame(2'b01, 1, 3, 3);
    clear_err();
    run_frame(2'b11, 2, 2, 2);
    run_frame(2'b01, 4, 3, 1);

    for (int n = 0; n < 120; n++) begin
      pat = 2'($urandom_range(3, 1));
      act = int'($urandom_range(4, 0));
      hc0 = ($urandom_range(5, 0) == 0) ? 0 : int'($urandom_range(4, 1));
      hc1 = ($urandom_range(5, 0) == 0) ? 0 : int'($urandom_range(4, 1));
      run_frame(pat, act, hc0, hc1);
      if ($urandom_range(3, 0) == 0) clear_err();
      repeat ($urandom_range(2, 0)) step();
    end

    // Async reset while the TX unit is running.
    check("queue_drained_before_reset", exp_q.size(), 0);
    bank_headcount0 = 8'd4;
    bank_ready = 2'b01;
    sys_enable = 1'b1;
    repeat (4) step();
    tx_pop = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx_en", tx_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_bank_pop", bank_pop, 0);
    check("async_rst_sent_count", sent_count, 0);
    tx_pop = 1'b0;
    bank_ready = 2'b00;
    m_last = 1; m_sent = 0; m_wd = 0; m_errwd = 0;
    step();
    check("async_rst_no_release", bank_release, 0);
    step();
    rst_n = 1'b1;
    step();

    // Saturate the watchdog counter.
    for (int n = 0; n < 260; n++) begin
      pat = 2'($urandom_range(3, 1));
      run_frame(pat, 1, int'($urandom_range(2, 1)), int'($urandom_range(2, 1)));
    end
    check("wd_err_count_saturated", wd_err_count, 255);
    run_frame(2'b10, 0, 1, 2);

    step();
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
